// File: rtl/nmea_src_arbiter_if.sv
// Signal bundle between the two GPS character sources, the arbiter and the parser.
// char0/char1 are single-cycle strobes with no backpressure. out_char is a single-cycle strobe that the parser must accept.
interface nmea_src_arbiter_if;
    logic [7:0] char0;
    logic       valid0;
    logic [7:0] char1;
    logic       valid1;
    logic [7:0] out_char;
    logic       out_valid;
    logic       parser_rst;
    logic [1:0] grant;
    logic [1:0] ovf;
    logic [7:0] abort_cnt;
    logic [1:0] dbg_state;
    logic [1:0] dbg_hunt;

    modport slave (
        input  char0, valid0, char1, valid1,
        output out_char, out_valid, parser_rst, grant, ovf, abort_cnt, dbg_state, dbg_hunt
    );

    modport master (
        output char0, valid0, char1, valid1,
        input  out_char, out_valid, parser_rst, grant, ovf, abort_cnt, dbg_state, dbg_hunt
    );
endinterface

// File: rtl/nmea_src_arbiter.sv
// Two-source NMEA sentence arbiter: per-source sentence filters and FIFOs feeding one parser,
// granted a whole sentence at a time, round-robin, with abort on stall, overlength or restart.
module nmea_src_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 82,
    parameter int TIMEOUT    = 65535
) (
    input logic              clk,
    input logic              rst,
    nmea_src_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] LF     = 8'h0A;

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_ABORT} state_e;
    typedef enum logic {F_HUNT, F_IN} filt_e;

    state_e          state_q, state_d;
    filt_e           filt_q [2];
    filt_e           filt_d [2];
    logic [7:0]      mem_q  [2][FIFO_DEPTH];
    logic [AW:0]     wptr_q [2];
    logic [AW:0]     wptr_d [2];
    logic [AW:0]     rptr_q [2];
    logic [AW:0]     rptr_d [2];
    logic [1:0]      ovf_q, ovf_d;
    logic            g_q, g_d;
    logic            rr_q, rr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [15:0]     to_q, to_d;
    logic [1:0]      grant_q, grant_d;
    logic [7:0]      out_char_q, out_char_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      abort_cnt_q, abort_cnt_d;

    logic [7:0]      in_char [2];
    logic [1:0]      in_valid;
    logic [7:0]      head    [2];
    logic [1:0]      empty, full, elig, push, pop;

    assign in_char[0] = bus.char0;
    assign in_char[1] = bus.char1;
    assign in_valid   = {bus.valid1, bus.valid0};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            head[s]  = mem_q[s][rptr_q[s][AW-1:0]];
            empty[s] = (wptr_q[s] == rptr_q[s]);
            full[s]  = ((wptr_q[s] - rptr_q[s]) == (AW+1)'(FIFO_DEPTH));
            elig[s]  = !empty[s] && (head[s] == DOLLAR);
        end
    end

    // Input filter: only sentence characters reach the FIFO; overflow resynchronises on the next '$'.
    always_comb begin
        ovf_d = ovf_q;
        push  = 2'b00;
        for (int s = 0; s < 2; s++) begin
            filt_d[s] = filt_q[s];
            if (in_valid[s] && (filt_q[s] == F_IN || in_char[s] == DOLLAR)) begin
                if (full[s]) begin
                    ovf_d[s]  = 1'b1;
                    filt_d[s] = F_HUNT;
                end else begin
                    push[s]   = 1'b1;
                    filt_d[s] = (in_char[s] == LF) ? F_HUNT : F_IN;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wptr_d[s] = wptr_q[s] + {{AW{1'b0}}, push[s]};
            rptr_d[s] = rptr_q[s] + {{AW{1'b0}}, pop[s]};
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_d        = rr_q;
        len_d       = len_q;
        to_d        = to_q;
        grant_d     = grant_q;
        out_char_d  = out_char_q;
        out_valid_d = 1'b0;
        abort_cnt_d = abort_cnt_q;
        pop         = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                len_d = '0;
                to_d  = '0;
                for (int s = 0; s < 2; s++) begin
                    if (!empty[s] && head[s] != DOLLAR) pop[s] = 1'b1;
                end
                if (elig != 2'b00) begin
                    g_d     = (elig == 2'b11) ? rr_q : elig[1];
                    grant_d = g_d ? 2'b10 : 2'b01;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                if (!empty[g_q]) begin
                    // A '$' after the first character means the source restarted: leave it for re-arbitration.
                    if (head[g_q] == DOLLAR && len_q != '0) begin
                        state_d = ST_ABORT;
                    end else begin
                        pop[g_q]    = 1'b1;
                        out_valid_d = 1'b1;
                        out_char_d  = head[g_q];
                        len_d       = len_q + LW'(1);
                        to_d        = '0;
                        if (head[g_q] == LF) begin
                            state_d = ST_IDLE;
                            rr_d    = ~g_q;
                            grant_d = 2'b00;
                        end else if (len_q == LW'(MAX_LEN - 1)) begin
                            state_d = ST_ABORT;
                        end
                    end
                end else begin
                    to_d = to_q + 16'd1;
                    if (to_q == 16'(TIMEOUT - 1)) state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                rr_d    = ~g_q;
                grant_d = 2'b00;
                len_d   = '0;
                to_d    = '0;
                if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ovf_q       <= 2'b00;
            g_q         <= 1'b0;
            rr_q        <= 1'b0;
            len_q       <= '0;
            to_q        <= '0;
            grant_q     <= 2'b00;
            out_char_q  <= 8'h00;
            out_valid_q <= 1'b0;
            abort_cnt_q <= 8'h00;
            for (int s = 0; s < 2; s++) begin
                filt_q[s] <= F_HUNT;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            g_q         <= g_d;
            rr_q        <= rr_d;
            len_q       <= len_d;
            to_q        <= to_d;
            grant_q     <= grant_d;
            out_char_q  <= out_char_d;
            out_valid_q <= out_valid_d;
            abort_cnt_q <= abort_cnt_d;
            for (int s = 0; s < 2; s++) begin
                filt_q[s] <= filt_d[s];
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) mem_q[s][wptr_q[s][AW-1:0]] <= in_char[s];
        end
    end

    assign bus.out_char   = out_char_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.parser_rst = (state_q == ST_ABORT);
    assign bus.grant      = grant_q;
    assign bus.ovf        = ovf_q;
    assign bus.abort_cnt  = abort_cnt_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_hunt   = {filt_q[1] == F_HUNT, filt_q[0] == F_HUNT};
endmodule

// File: tb/tb_nmea_src_arbiter.sv
// Bench for nmea_src_arbiter: queue-based reference model checked every cycle, plus literal
// expectations on the forwarded character streams, abort counts and flags for each directed scenario.
module tb_nmea_src_arbiter;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_LEN    = 82;
    localparam int TIMEOUT    = 20;
    localparam int M_IDLE     = 0;
    localparam int M_FWD      = 1;
    localparam int M_ABORT    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    nmea_src_arbiter_if bus();

    nmea_src_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: sources as byte queues, arbitration expressed per sentence rules.
    logic [7:0] mq [2][$];
    int         m_mode, m_src, m_rr, m_len, m_wait;
    logic [1:0] m_hunt, m_ovf, m_grant;
    logic [7:0] m_out_char, m_abort_cnt;
    logic       m_out_valid;

    function automatic bit starts(input int s);
        return (mq[s].size() > 0) && (mq[s][0] == 8'h24);
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] ic [2];
        logic       iv [2];
        bit         full [2];
        bit         pop  [2];
        ic[0] = bus.char0;  iv[0] = bus.valid0;
        ic[1] = bus.char1;  iv[1] = bus.valid1;
        if (!rst) begin
            mq[0].delete();
            mq[1].delete();
            m_mode = M_IDLE; m_rr = 0; m_src = 0; m_len = 0; m_wait = 0;
            m_hunt = 2'b11; m_ovf = 2'b00; m_grant = 2'b00;
            m_out_char = 8'h00; m_out_valid = 1'b0; m_abort_cnt = 8'h00;
        end else begin
            for (int s = 0; s < 2; s++) begin
                full[s] = (mq[s].size() >= FIFO_DEPTH);
                pop[s]  = 1'b0;
            end
            m_out_valid = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    m_len = 0;
                    m_wait = 0;
                    for (int s = 0; s < 2; s++)
                        if (mq[s].size() > 0 && mq[s][0] != 8'h24) pop[s] = 1'b1;
                    if (starts(0) || starts(1)) begin
                        m_src   = (starts(0) && starts(1)) ? m_rr : (starts(1) ? 1 : 0);
                        m_grant = (m_src == 1) ? 2'b10 : 2'b01;
                        m_mode  = M_FWD;
                    end
                end
                M_FWD: begin
                    if (mq[m_src].size() == 0) begin
                        m_wait++;
                        if (m_wait == TIMEOUT) m_mode = M_ABORT;
                    end else if (mq[m_src][0] == 8'h24 && m_len > 0) begin
                        m_mode = M_ABORT;
                    end else begin
                        pop[m_src]  = 1'b1;
                        m_out_valid = 1'b1;
                        m_out_char  = mq[m_src][0];
                        m_len++;
                        m_wait = 0;
                        if (m_out_char == 8'h0A) begin
                            m_mode = M_IDLE; m_rr = 1 - m_src; m_grant = 2'b00;
                        end else if (m_len == MAX_LEN) begin
                            m_mode = M_ABORT;
                        end
                    end
                end
                default: begin
                    m_mode = M_IDLE; m_rr = 1 - m_src; m_grant = 2'b00;
                    m_len = 0; m_wait = 0;
                    if (m_abort_cnt != 8'hFF) m_abort_cnt = m_abort_cnt + 8'd1;
                end
            endcase
            for (int s = 0; s < 2; s++)
                if (pop[s]) void'(mq[s].pop_front());
            for (int s = 0; s < 2; s++) begin
                if (iv[s] && (!m_hunt[s] || ic[s] == 8'h24)) begin
                    if (full[s]) begin
                        m_ovf[s]  = 1'b1;
                        m_hunt[s] = 1'b1;
                    end else begin
                        mq[s].push_back(ic[s]);
                        m_hunt[s] = (ic[s] == 8'h0A);
                    end
                end
            end
        end
    end

    // Per-cycle compare and stream capture, sampled mid-cycle.
    logic [7:0] got_q [$];
    logic [7:0] m_got_q [$];
    int cyc = 0, n_prst = 0, prst_cyc = 0, last_ov_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            got_q.delete();
            m_got_q.delete();
            n_prst = 0;
        end else begin
            if (bus.out_valid) begin
                got_q.push_back(bus.out_char);
                last_ov_cyc = cyc;
            end
            if (m_out_valid) m_got_q.push_back(m_out_char);
            if (bus.parser_rst) begin
                n_prst++;
                prst_cyc = cyc;
            end
        end
        if (cmp_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
            if (m_out_valid) check("out_char", 32'(bus.out_char), 32'(m_out_char));
            check("parser_rst", 32'(bus.parser_rst), 32'(m_mode == M_ABORT));
            check("grant", 32'(bus.grant), 32'(m_grant));
            check("ovf", 32'(bus.ovf), 32'(m_ovf));
            check("abort_cnt", 32'(bus.abort_cnt), 32'(m_abort_cnt));
            check("hunt", 32'(bus.dbg_hunt), 32'(m_hunt));
        end
    end

    task automatic drive(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
        bus.valid0 = v0;
        bus.char0  = c0;
        bus.valid1 = v1;
        bus.char1  = c1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.valid0 = 1'b0; bus.char0 = 8'h00;
        bus.valid1 = 1'b0; bus.char1 = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_char", 32'(bus.out_char), 32'd0);
        check("rst_parser_rst", 32'(bus.parser_rst), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_abort_cnt", 32'(bus.abort_cnt), 32'd0);
        cmp_en = 1'b1;
        rst = 1'b1;
    endtask

    // Source 0 sends s0 every gap0 cycles from cycle 0; source 1 sends s1 every gap1 cycles from off1.
    task automatic send_pair(input string s0, input int gap0, input string s1, input int off1, input int gap1);
        int n0, n1, n;
        logic v0, v1;
        logic [7:0] c0, c1;
        n0 = s0.len() * gap0;
        n1 = off1 + s1.len() * gap1;
        n  = (n0 > n1) ? n0 : n1;
        for (int c = 0; c < n; c++) begin
            v0 = 1'b0; c0 = 8'h00; v1 = 1'b0; c1 = 8'h00;
            if (c % gap0 == 0 && c / gap0 < s0.len()) begin
                v0 = 1'b1;
                c0 = s0[c / gap0];
            end
            if (c >= off1 && (c - off1) % gap1 == 0 && (c - off1) / gap1 < s1.len()) begin
                v1 = 1'b1;
                c1 = s1[(c - off1) / gap1];
            end
            drive(v0, c0, v1, c1);
        end
    endtask

    task automatic check_stream(input string name, input string exp);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp.len()));
        check({name, "_model_len"}, 32'(m_got_q.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < got_q.size(); i++)
            check({name, "_char"}, 32'(got_q[i]), 32'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string s6;
        s6 = "$";
        for (int i = 0; i < 8; i++) s6 = {s6, "ABCDEFGHIJ"};
        s6 = {s6, "ABCDEFGHI"};

        // Single paced sentence from source 0.
        do_reset();
        send_pair("$GPRMC,123519,A\r\n", 3, "", 0, 1);
        idle(30);
        check_stream("t1", "$GPRMC,123519,A\r\n");
        check("t1_grant_idle", 32'(bus.grant), 32'd0);
        check("t1_abort_cnt", 32'(bus.abort_cnt), 32'd0);
        check("t1_prst", 32'(n_prst), 32'd0);

        // Simultaneous '$' after reset: source 0 first, source 1 intact afterwards.
        do_reset();
        send_pair("$AB\n", 1, "$CD\n", 0, 1);
        idle(30);
        check_stream("t2", "$AB\n$CD\n");
        check("t2_prst", 32'(n_prst), 32'd0);

        // Stalled sentence times out; the late tail is scrubbed.
        do_reset();
        send_pair("$GPRMC,12", 1, "", 0, 1);
        idle(40);
        send_pair("3519\r\n", 1, "", 0, 1);
        idle(20);
        check_stream("t3", "$GPRMC,12");
        check("t3_prst", 32'(n_prst), 32'd1);
        check("t3_timeout_gap", 32'(prst_cyc - last_ov_cyc), 32'd20);
        check("t3_abort_cnt", 32'(bus.abort_cnt), 32'd1);

        // Restarted sentence: fragment forwarded, abort, then full re-granted sentence.
        do_reset();
        send_pair("", 1, "$GPR$GPRMC,1\r\n", 0, 2);
        idle(30);
        check_stream("t4", "$GPR$GPRMC,1\r\n");
        check("t4_prst", 32'(n_prst), 32'd1);
        check("t4_abort_cnt", 32'(bus.abort_cnt), 32'd1);

        // Source 1 overflows while source 0 holds the grant.
        do_reset();
        send_pair("$GPGLL,4916\r\n", 3, "$GPGSV,1,1", 6, 1);
        check("t5_hunt1", 32'(bus.dbg_hunt[1]), 32'd1);
        idle(40);
        check_stream("t5", "$GPGLL,4916\r\n$GPG");
        check("t5_ovf", 32'(bus.ovf), 32'd2);
        check("t5_prst", 32'(n_prst), 32'd1);
        check("t5_abort_cnt", 32'(bus.abort_cnt), 32'd1);

        // Overlong sentence is cut at MAX_LEN and the rest scrubbed.
        do_reset();
        send_pair(s6, 1, "", 0, 1);
        idle(30);
        check_stream("t6", s6.substr(0, MAX_LEN - 1));
        check("t6_prst", 32'(n_prst), 32'd1);
        check("t6_abort_cnt", 32'(bus.abort_cnt), 32'd1);
        check("t6_grant_idle", 32'(bus.grant), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nmea_src_arbiter.md
Name: nmea_src_arbiter

Overview:
- Shares one NMEA sentence parser between two GPS character streams (primary and backup UART receivers).
- Buffers each stream in a per-source FIFO that holds only sentence characters.
- Grants the parser one whole sentence at a time, round-robin.
- Aborts stalled, overlong or truncated sentences and pulses a parser reset so the parser always restarts cleanly.

Parameters:
- FIFO_DEPTH, 16, per-source FIFO depth in characters (power of 2, 4..256)
- MAX_LEN, 82, maximum forwarded characters per sentence, including '$' and '\n'
- TIMEOUT, 65535, idle cycles allowed mid-sentence while the granted FIFO is empty (counter width 16)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-low
- char0  in  8  source 0 character
- valid0  in  1  char0 strobe (one cycle per character)
- char1  in  8  source 1 character
- valid1  in  1  char1 strobe
- out_char  out  8  character to the parser
- out_valid  out  1  out_char strobe
- parser_rst  out  1  one-cycle active-high abort pulse to the parser
- grant  out  2  one-hot granted source; 00 when idle
- ovf  out  2  sticky per-source FIFO overflow flags
- abort_cnt  out  8  saturating count of aborted sentences

Behaviour:
- Reset (rst==0 at posedge): FIFOs empty, filters in HUNT, state IDLE, rr pointer=0. Outputs out_char=0, out_valid=0, parser_rst=0, grant=00, ovf=00, abort_cnt=0.
- Input filter, per source (HUNT / IN):
  - HUNT: '$' (0x24) is pushed and the filter goes to IN; all other characters are dropped.
  - IN: every character is pushed; '\n' (0x0A) returns the filter to HUNT.
  - IN receiving '$': push it and stay IN. The arbiter treats it as the start of a new sentence.
  - Push when FIFO full: character dropped, ovf[s] set (sticky until reset), filter forced to HUNT.
- FIFO: registered; a character written at edge t is visible at the head in cycle t+1. A push and a pop in the same cycle are allowed when the FIFO is not empty.
- State IDLE:
  - A source is eligible when its FIFO is non-empty and its head is '$'.
  - A non-eligible source with a non-'$' head is popped and discarded (scrub), one character per cycle per source, in parallel.
  - One source eligible: grant it. Both eligible: grant source rr. Then go to FWD, with grant updated at the same edge.
- State FWD (granted source g):
  - Each cycle, if FIFO[g] is non-empty, pop the head. Register it to out_char with out_valid=1 on the next cycle; increment len; clear the timeout counter.
  - Popped '\n': go IDLE, rr=~g, grant=00.
  - Head is '$' and len>0: do not pop it; go ABORT. That '$' remains for the next arbitration.
  - len==MAX_LEN and the last popped character is not '\n': go ABORT. The remainder is scrubbed in IDLE.
  - FIFO[g] empty: increment the timeout counter; on reaching TIMEOUT, go ABORT.
  - The non-granted source is only pushed, never popped, in FWD.
- State ABORT (1 cycle):
  - parser_rst=1, out_valid=0, abort_cnt+1 (saturates at 255).
  - rr=~g, grant=00, len and timeout counter cleared, then IDLE.
- Latency: '$' pushed at edge t into an idle system → grant at edge t+1 → pop in cycle t+2 → out_valid in cycle t+3. Steady state is one character per cycle while data is available.
- out_valid never asserts in IDLE or ABORT except for the registered output of a pop made in the preceding FWD cycle. Every character of a sentence, from '$' to '\n', comes from a single source.
- Reset mid-sentence: everything cleared immediately. No parser_rst pulse is generated; the parent resets the parser from the same reset.

Test Plan:
- Reset then source 0 sends "$GPRMC,123519,A\r\n" one character every 3 cycles → same 17 bytes on out_char in order, grant=01 throughout, grant=00 after '\n', abort_cnt=0.
- Both sources present '$' at the same edge after reset → source 0 granted and forwarded first. Source 1's sentence follows intact, with no interleaving of characters.
- Source 0 sends "$GPRMC,12" then stops; TIMEOUT=20 → parser_rst pulses once 20 cycles after the last pop, abort_cnt=1. A later "3519\r\n" from source 0 is scrubbed and never appears on out_char.
- Source 1 sends "$GPR$GPRMC,...\r\n" → "$GPR" forwarded, then parser_rst pulse. The second sentence is re-granted and forwarded in full, starting at '$'.
- FIFO_DEPTH=4, source 1 bursts 10 characters while source 0 holds the grant → ovf=10, source 1 filter in HUNT, the truncated sentence aborts on its next '$' or timeout.
- 90 characters without '\n', MAX_LEN=82 → exactly 82 characters on out_char, then a parser_rst pulse and the remaining 8 scrubbed.
